l2_mem_responder: RTL



---
 rtl/l2_mem_pkg.sv | 19 +
 rtl/l2_mem_line_array.sv | 44 ++++
 rtl/l2_mem_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/l2_mem_pkg.sv
// rtl/l2_mem_pkg.sv - shared types and widths for the L2<->MEM line responder
package l2_mem_pkg;

    localparam int L2_LINE_W = 512;
    localparam int L2_ADDR_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                 write;
        logic [L2_ADDR_W-1:0] addr;
        logic [L2_LINE_W-1:0] data;
    } req_t;

endpackage

// File: rtl/l2_mem_line_array.sv
// rtl/l2_mem_line_array.sv - DEPTH x LINE_W line store, one sync write port, one sync read port
module mem_line_array #(
    parameter int LINE_W = 512,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [LINE_W-1:0] rd_data
);

    logic [LINE_W-1:0] mem [DEPTH];
    logic [LINE_W-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register only loads on a read enable, so it holds across writes and idle time.
    always_comb begin
        rd_data_d = rd_data_q;
        if (re) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/l2_mem_responder.sv
// rtl/l2_mem_responder.sv - memory-side responder for L2 refills/writebacks, fixed latency
// Optional request counters are enabled with `define L2_MEM_STATS_EN.
module l2_mem_responder
    import l2_mem_pkg::*;
#(
    parameter int LINE_W  = L2_LINE_W,
    parameter int DEPTH   = 4096,
    parameter int ADDR_W  = L2_ADDR_W,
    parameter int LATENCY = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_L2_MEM,
    output logic              req_ready_MEM_L2,
    input  logic              req_write_L2_MEM,
    input  logic [ADDR_W-1:0] addr_L2_MEM,
    input  logic [LINE_W-1:0] write_data_L2_MEM,
    output logic              resp_valid_MEM_L2,
    input  logic              resp_ready_L2_MEM,
    output logic [LINE_W-1:0] read_data_MEM_L2
`ifdef L2_MEM_STATS_EN
    ,
    output logic [31:0]       rd_count_MEM,
    output logic [31:0]       wr_count_MEM
`endif
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // The captured-request struct is sized from the package, so widths must match it.
    if (LATENCY < 1 || (1 << ADDR_W) != DEPTH ||
        LINE_W != L2_LINE_W || ADDR_W != L2_ADDR_W) begin : g_param_check
        $error("l2_mem_responder: illegal LATENCY/DEPTH/ADDR_W/LINE_W combination");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    logic             resp_valid_q, resp_valid_d;
    logic             req_ready_q, req_ready_d;

    logic accept;
    logic commit;
    logic handshake;

    assign accept    = req_valid_L2_MEM & req_ready_q;
    assign commit    = (state_q == WAIT) && (cnt_q == '0);
    assign handshake = (state_q == RESP) & resp_ready_L2_MEM;

    // A LATENCY of 1 loads the counter with zero, so the edge after acceptance enters RESP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d.write = req_write_L2_MEM;
                    req_d.addr  = addr_L2_MEM;
                    req_d.data  = write_data_L2_MEM;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (handshake) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
        end
    end

    mem_line_array #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .we      (commit & req_q.write),
        .wr_addr (req_q.addr),
        .wr_data (req_q.data),
        .re      (commit & ~req_q.write),
        .rd_addr (req_q.addr),
        .rd_data (read_data_MEM_L2)
    );

    assign req_ready_MEM_L2  = req_ready_q;
    assign resp_valid_MEM_L2 = resp_valid_q;

`ifdef L2_MEM_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (handshake) begin
            if (req_q.write) begin
                wr_count_d = wr_count_q + 32'd1;
            end else begin
                rd_count_d = rd_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count_MEM = rd_count_q;
    assign wr_count_MEM = wr_count_q;
`endif

endmodule
